// File: rtl/mem_port_arbiter.sv
// Shares one single-port, 1-cycle-latency memory between instruction fetch (IF) and
// load/store (D): D has priority, IF is forced through after MAX_STARVE consecutive losses.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_STARVE = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    if_req_i,
    input  logic [ADDR_WIDTH-1:0]   if_addr_i,
    output logic                    if_gnt_o,
    input  logic                    if_flush_i,
    output logic                    if_rvalid_o,
    output logic [DATA_WIDTH-1:0]   if_rdata_o,

    input  logic                    d_req_i,
    input  logic                    d_we_i,
    input  logic [ADDR_WIDTH-1:0]   d_addr_i,
    input  logic [DATA_WIDTH-1:0]   d_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] d_wmask_i,
    output logic                    d_gnt_o,
    output logic                    d_rvalid_o,
    output logic [DATA_WIDTH-1:0]   d_rdata_o,

    output logic                    mem_en_o,
    output logic                    mem_we_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0] mem_wmask_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

    localparam int unsigned MaskWidth = DATA_WIDTH / 8;
    localparam int unsigned CntWidth  = $clog2(MAX_STARVE + 1);
    localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MAX_STARVE);

    typedef enum logic {
        OwnerIf = 1'b0,
        OwnerD  = 1'b1
    } owner_e;

    if (MAX_STARVE < 1) begin : g_bad_param
        $error("mem_port_arbiter: MAX_STARVE must be at least 1");
    end

    logic                force_if;
    logic                if_gnt;
    logic                d_gnt;

    logic                resp_pending_q, resp_pending_d;
    owner_e              resp_owner_q, resp_owner_d;
    logic [CntWidth-1:0] starve_cnt_q, starve_cnt_d;

    // Grant decision; reset suppresses both grants so nothing reaches memory.
    always_comb begin
        force_if = if_req_i && (starve_cnt_q == MaxCnt);
        if_gnt   = 1'b0;
        d_gnt    = 1'b0;
        if (!rst_i) begin
            d_gnt  = d_req_i && !force_if;
            if_gnt = if_req_i && (!d_req_i || force_if);
        end
    end

    assign if_gnt_o = if_gnt;
    assign d_gnt_o  = d_gnt;

    always_comb begin
        mem_en_o    = if_gnt | d_gnt;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_wmask_o = '0;
        if (d_gnt) begin
            mem_we_o    = d_we_i;
            mem_addr_o  = d_addr_i;
            mem_wdata_o = d_wdata_i;
            mem_wmask_o = d_we_i ? d_wmask_i : {MaskWidth{1'b0}};
        end else if (if_gnt) begin
            mem_addr_o  = if_addr_i;
        end
    end

    always_comb begin
        resp_pending_d = if_gnt | d_gnt;
        resp_owner_d   = d_gnt ? OwnerD : OwnerIf;
        starve_cnt_d   = starve_cnt_q;
        if (if_gnt || !if_req_i) begin
            starve_cnt_d = '0;
        end else if (d_gnt && (starve_cnt_q != MaxCnt)) begin
            starve_cnt_d = starve_cnt_q + CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_pending_q <= 1'b0;
            resp_owner_q   <= OwnerIf;
            starve_cnt_q   <= '0;
        end else begin
            resp_pending_q <= resp_pending_d;
            resp_owner_q   <= resp_owner_d;
            starve_cnt_q   <= starve_cnt_d;
        end
    end

    // Reset and flush act combinationally so the in-flight response dies in the same cycle.
    always_comb begin
        if_rvalid_o = resp_pending_q && (resp_owner_q == OwnerIf) && !if_flush_i && !rst_i;
        d_rvalid_o  = resp_pending_q && (resp_owner_q == OwnerD) && !rst_i;
        if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
        d_rdata_o   = d_rvalid_o ? mem_rdata_i : '0;
    end

    a_one_grant : assert property (@(posedge clk_i) !(if_gnt && d_gnt));
    a_cnt_range : assert property (@(posedge clk_i) starve_cnt_q <= MaxCnt);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: hand table, directed corner sequences and random traffic,
// all cross-checked every cycle against a cycle-level reference model and a memory array.
module tb_mem_port_arbiter;

    localparam int unsigned MaxStarve = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, if_req, if_flush, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [3:0]  d_wmask;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    mem_port_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .MAX_STARVE(MaxStarve)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt), .if_flush_i(if_flush),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_wmask_i(d_wmask), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_wmask_o(mem_wmask), .mem_rdata_i(mem_rdata)
    );

    // Word-indexed single-port memory with 1-cycle read latency.
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_wmask[b]) mem[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end else begin
                mem_rdata <= mem[mem_addr[7:0]];
            end
        end
    end

    int n_checks;
    int n_errors;

    // Reference model state: IF losses since it last got through, and the response owed.
    int          m_starve, n_starve;
    bit          m_pend_if, m_pend_d, m_pend_we, n_pend_if, n_pend_d, n_pend_we;
    logic [31:0] m_data, n_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic settle();
        bit          g_if, g_d, force_if, exp_irv, exp_drv, exp_we;
        logic [31:0] exp_addr, exp_wdata;
        logic [3:0]  exp_wmask;
        #4;
        force_if  = if_req && (m_starve >= MaxStarve);
        g_d       = !rst && d_req && !force_if;
        g_if      = !rst && if_req && !g_d;
        exp_we    = g_d && d_we;
        exp_addr  = g_d ? d_addr : (g_if ? if_addr : 32'h0);
        exp_wdata = g_d ? d_wdata : 32'h0;
        exp_wmask = exp_we ? d_wmask : 4'h0;
        check("if_gnt", 32'(if_gnt), 32'(g_if));
        check("d_gnt", 32'(d_gnt), 32'(g_d));
        check("mem_en", 32'(mem_en), 32'(g_if || g_d));
        check("mem_we", 32'(mem_we), 32'(exp_we));
        check("mem_addr", mem_addr, exp_addr);
        check("mem_wmask", 32'(mem_wmask), 32'(exp_wmask));
        if (!g_if) check("mem_wdata", mem_wdata, exp_wdata);

        exp_irv = m_pend_if && !if_flush && !rst;
        exp_drv = m_pend_d && !rst;
        check("if_rvalid", 32'(if_rvalid), 32'(exp_irv));
        check("d_rvalid", 32'(d_rvalid), 32'(exp_drv));
        check("if_rdata", if_rdata, exp_irv ? m_data : 32'h0);
        if (!exp_drv) check("d_rdata_idle", d_rdata, 32'h0);
        else if (!m_pend_we) check("d_rdata", d_rdata, m_data);

        n_pend_if = g_if;
        n_pend_d  = g_d;
        n_pend_we = exp_we;
        n_data    = mem[exp_addr[7:0]];
        if (rst || g_if || !if_req) n_starve = 0;
        else n_starve = (m_starve < MaxStarve) ? m_starve + 1 : MaxStarve;
    endtask

    task automatic tick();
        @(posedge clk);
        m_pend_if = n_pend_if;
        m_pend_d  = n_pend_d;
        m_pend_we = n_pend_we;
        m_data    = n_data;
        m_starve  = n_starve;
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; if_req = 1'b0; if_flush = 1'b0; if_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_wmask = 4'h0;
    endtask

    // Row fields: rst if_req d_req d_we if_flush _ if_gnt d_gnt if_rvalid d_rvalid
    typedef struct packed {
        bit rst, ifr, dr, dwe, fl;
        bit ig, dg, irv, drv;
    } vec_t;
    vec_t tbl [24];

    initial begin
        n_checks = 0; n_errors = 0;
        m_starve = 0; m_pend_if = 0; m_pend_d = 0; m_pend_we = 0; m_data = 32'h0;
        idle_inputs();

        tbl[0]  = 9'b11100_0000;  tbl[1]  = 9'b11100_0000;  tbl[2]  = 9'b00000_0000;
        tbl[3]  = 9'b00000_0000;  tbl[4]  = 9'b01100_0100;  tbl[5]  = 9'b01100_0101;
        tbl[6]  = 9'b01100_0101;  tbl[7]  = 9'b01100_0101;  tbl[8]  = 9'b01100_1001;
        tbl[9]  = 9'b01100_0110;  tbl[10] = 9'b01100_0101;  tbl[11] = 9'b01100_0101;
        tbl[12] = 9'b01100_0101;  tbl[13] = 9'b01100_1001;  tbl[14] = 9'b01001_1000;
        tbl[15] = 9'b00000_0010;  tbl[16] = 9'b01100_0100;  tbl[17] = 9'b00110_0101;
        tbl[18] = 9'b01100_0101;  tbl[19] = 9'b11100_0000;  tbl[20] = 9'b01100_0100;
        tbl[21] = 9'b00101_0101;  tbl[22] = 9'b00000_0001;  tbl[23] = 9'b00000_0000;

        for (int i = 0; i < 24; i++) begin
            rst = tbl[i].rst; if_req = tbl[i].ifr; d_req = tbl[i].dr;
            d_we = tbl[i].dwe; if_flush = tbl[i].fl;
            if_addr = 32'(i); d_addr = 32'h40 + 32'(i); d_wdata = $urandom; d_wmask = 4'hF;
            settle();
            check("tbl_if_gnt", 32'(if_gnt), 32'(tbl[i].ig));
            check("tbl_d_gnt", 32'(d_gnt), 32'(tbl[i].dg));
            check("tbl_if_rvalid", 32'(if_rvalid), 32'(tbl[i].irv));
            check("tbl_d_rvalid", 32'(d_rvalid), 32'(tbl[i].drv));
            tick();
        end

        // Preload 0x10 and clear 0x20 through the D port.
        idle_inputs();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEADBEEF; d_wmask = 4'hF;
        settle(); tick();
        d_addr = 32'h20; d_wdata = 32'h0;
        settle(); tick();
        idle_inputs();
        settle(); tick();

        // Fetch only.
        if_req = 1'b1; if_addr = 32'h10;
        settle();
        check("fetch_gnt", 32'(if_gnt), 32'd1);
        check("fetch_mem_en", 32'(mem_en), 32'd1);
        check("fetch_mem_we", 32'(mem_we), 32'd0);
        check("fetch_mem_addr", mem_addr, 32'h10);
        tick();
        if_req = 1'b0;
        settle();
        check("fetch_rvalid", 32'(if_rvalid), 32'd1);
        check("fetch_rdata", if_rdata, 32'hDEADBEEF);
        tick();

        // Masked write then read back.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h11223344; d_wmask = 4'b0101;
        settle();
        check("wr_gnt", 32'(d_gnt), 32'd1);
        check("wr_mem_we", 32'(mem_we), 32'd1);
        check("wr_mem_wmask", 32'(mem_wmask), 32'b0101);
        tick();
        d_we = 1'b0;
        settle();
        check("wr_ack", 32'(d_rvalid), 32'd1);
        tick();
        idle_inputs();
        settle();
        check("rd_rvalid", 32'(d_rvalid), 32'd1);
        check("rd_rdata", d_rdata, 32'h00220044);
        tick();

        // Reset mid-flight with a partly advanced starvation count.
        if_req = 1'b1; if_addr = 32'h5; d_req = 1'b1; d_addr = 32'h6;
        settle(); tick();
        settle(); tick();
        settle();
        check("mid_d_gnt", 32'(d_gnt), 32'd1);
        tick();
        rst = 1'b1;
        settle();
        check("rst_d_rvalid", 32'(d_rvalid), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        tick();
        idle_inputs();
        settle();
        check("post_rst_d_rvalid", 32'(d_rvalid), 32'd0);
        tick();
        if_req = 1'b1; d_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            settle();
            check("post_rst_d_gnt", 32'(d_gnt), 32'(k < 4));
            check("post_rst_if_gnt", 32'(if_gnt), 32'(k == 4));
            tick();
        end

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            rst      = ($urandom_range(0, 63) == 0);
            if_req   = ($urandom_range(0, 3) != 0);
            d_req    = ($urandom_range(0, 3) != 0);
            d_we     = $urandom_range(0, 1) == 1;
            if_flush = ($urandom_range(0, 9) == 0);
            if_addr  = 32'($urandom_range(0, 255));
            d_addr   = 32'($urandom_range(0, 255));
            d_wdata  = $urandom;
            d_wmask  = 4'($urandom_range(0, 15));
            settle();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory (1-cycle read latency) between two requesters: instruction fetch (IF) and load/store (D).
- Sits between the core and a unified memory, in place of separate instruction and data memories.
- Fixed priority to D, with a starvation guard for IF.
- Response routing is pipelined: one transaction is issued per cycle, and each response returns to its owner on the next cycle.
- Supports fetch flush, which drops an in-flight fetch response on a redirect.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width. Mask width is DATA_WIDTH/8.
- MAX_STARVE, 4, number of consecutive D grants allowed while IF waits before IF is forced through. Must be at least 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request.
- if_addr  in  ADDR_WIDTH  fetch address.
- if_gnt  out  1  fetch request accepted this cycle (combinational).
- if_flush  in  1  discard any fetch response due next cycle.
- if_rvalid  out  1  fetch data valid.
- if_rdata  out  DATA_WIDTH  fetch data.
- d_req  in  1  data request.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  write data.
- d_wmask  in  DATA_WIDTH/8  byte write mask.
- d_gnt  out  1  data request accepted (combinational).
- d_rvalid  out  1  data response (read data or write ack).
- d_rdata  out  DATA_WIDTH  read data.
- mem_en  out  1  memory access this cycle.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_wmask  out  DATA_WIDTH/8  memory byte mask.
- mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after mem_en with mem_we=0.

Behaviour:
- Reset (synchronous, active-high):
  - Clears if_rvalid, d_rvalid, resp_owner (1 bit), resp_pending and starve_cnt to 0.
  - While rst=1, if_gnt, d_gnt and mem_en are forced to 0.
- Grant (combinational, at most one grant per cycle):
  - force_if = if_req && starve_cnt == MAX_STARVE.
  - d_gnt = d_req && !force_if.
  - if_gnt = if_req && (!d_req || force_if).
  - No request from either side: no grant, mem_en=0.
- Memory drive: mem_en = if_gnt | d_gnt. Address, data and mask are muxed from the granted requester.
  - IF grant: mem_we=0, mem_wmask=0.
  - D grant: mem_we=d_we. mem_wmask=d_wmask on writes, 0 on reads.
  - No grant: mem_addr, mem_wdata and mem_wmask drive 0.
- Requester rule: req, addr, we, wdata and wmask must be held stable until the cycle gnt=1. Dropping req before gnt is allowed (abandons the request).
- Response (registered):
  - A grant at cycle t produces rvalid=1 to that owner at cycle t+1 for exactly 1 cycle.
  - D writes also get d_rvalid (ack). d_rdata is unspecified-but-stable mem_rdata on a write ack; the bench must not check it.
  - rdata = mem_rdata when the matching rvalid=1, otherwise 0.
  - Back-to-back grants yield back-to-back responses with no bubble.
- Flush:
  - if_flush=1 in cycle t cancels a fetch granted in cycle t-1: if_rvalid is forced 0 in cycle t, and if_rdata=0.
  - if_flush in the same cycle as a new if_gnt does not cancel that new grant.
  - Flush has no effect on D responses.
- Starvation counter:
  - d_gnt && if_req: starve_cnt++ (saturates at MAX_STARVE).
  - if_gnt or !if_req: starve_cnt = 0.
  - When the counter reaches MAX_STARVE, the next cycle with if_req grants IF even if d_req=1; d_gnt=0 that cycle.
- Reset mid-operation: an in-flight response is dropped (rvalid=0 the cycle after rst) and the counter clears.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with both req=1 -> if_gnt=d_gnt=mem_en=0. After release, outputs 0 until a req is presented.
- Fetch only: preload mem[0x10]=0xDEADBEEF. if_req=1, if_addr=0x10 at cycle t -> if_gnt=1, mem_en=1, mem_we=0 at t; if_rvalid=1, if_rdata=0xDEADBEEF at t+1.
- Contention: both req every cycle, MAX_STARVE=4 -> grant pattern D,D,D,D,IF,D,D,D,D,IF. Each response lands on the correct owner one cycle later.
- Write then read: d_we=1, d_addr=0x20, d_wdata=0x11223344, d_wmask=0b0101 -> mem_wmask=0b0101, d_rvalid=1 next cycle. Then a read of 0x20 (prior contents 0) -> d_rdata=0x00220044.
- Flush: fetch granted at t, if_flush=1 at t+1 -> if_rvalid=0 at t+1. A new fetch granted at t+1 -> if_rvalid=1 at t+2.
- Reset mid-flight: D read granted at t, rst=1 at t+1 -> d_rvalid=0 at t+1 and t+2; starve_cnt returns to 0 (checked via a fresh contention run matching the D×4, IF pattern).
